pair_seq_monitor: RTL and testbench

Downstream checker for the free-running 64-step pair counter. Each sampled cycle it receives an even/odd 7-bit code pair (A = even code, B = odd code, both sharing the same 6-bit count). It verifies pair consistency and step-by-2 sequence continuity, locks after a run of good samples, and counts sequence errors and wrap-arounds for status display.

---
 rtl/pair_chk_pkg.sv | 16 +
 rtl/pair_check.sv | 21 ++
 rtl/pair_seq_monitor.sv | 123 ++++++++++++
 tb/tb_pair_seq_monitor.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pair_chk_pkg.sv
// Shared types and constants for the pair-counter sequence monitor.
package pair_chk_pkg;

  localparam int CODE_W    = 7;
  localparam int STEP      = 2;
  localparam int WRAP_LAST = 126;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_LOST   = 2'd3
  } pair_state_t;

endpackage

// File: rtl/pair_check.sv
// Combinational pair/sequence qualifier for one even/odd code sample.
module pair_check
  import pair_chk_pkg::*;
(
  input  logic [CODE_W-1:0] in_a,
  input  logic [CODE_W-1:0] in_b,
  input  logic [CODE_W-1:0] last_a,
  output logic              pair_ok,
  output logic              seq_ok,
  output logic              wrap
);

  logic [CODE_W-1:0] next_a;

  // Carry out of the 7-bit add is dropped so 126 + 2 lands on 0.
  assign next_a  = last_a + CODE_W'(STEP);
  assign pair_ok = ~in_a[0] & in_b[0] & (in_a[CODE_W-1:1] == in_b[CODE_W-1:1]);
  assign seq_ok  = (in_a == next_a);
  assign wrap    = pair_ok & seq_ok & (last_a == CODE_W'(WRAP_LAST)) & (in_a == '0);

endmodule

// File: rtl/pair_seq_monitor.sv
// Lock FSM plus error/wrap status counters for the 64-step pair counter stream.
module pair_seq_monitor
  import pair_chk_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [CODE_W-1:0] in_a,
  input  logic [CODE_W-1:0] in_b,
  input  logic              clr_err,
  output logic [1:0]        state,
  output logic              locked,
  output logic              err_flag,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  wrap_count,
  output logic [CODE_W-1:0] last_a
);

  localparam logic [3:0]       LOCK_C  = 4'(LOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pair_state_t       state_q;
  logic [3:0]        good_cnt_q;
  logic [3:0]        gc_inc;
  logic [CODE_W-1:0] last_a_q;
  logic              err_flag_q,   err_flag_d;
  logic [CNT_W-1:0]  err_count_q,  err_count_d;
  logic [CNT_W-1:0]  wrap_count_q, wrap_count_d;

  logic pair_ok, seq_ok, wrap, good, lock_fail;

  pair_check u_check (
    .in_a    (in_a),
    .in_b    (in_b),
    .last_a  (last_a_q),
    .pair_ok (pair_ok),
    .seq_ok  (seq_ok),
    .wrap    (wrap)
  );

  assign good      = pair_ok & seq_ok;
  assign gc_inc    = good_cnt_q + 4'd1;
  assign lock_fail = en & (state_q == ST_LOCKED) & ~good;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      good_cnt_q <= 4'd0;
      last_a_q   <= '0;
    end else if (en) begin
      last_a_q <= in_a;
      case (state_q)
        ST_IDLE: begin
          // Sequence continuity is meaningless before the first good pair.
          if (pair_ok) begin
            good_cnt_q <= 4'd1;
            state_q    <= (LOCK_C == 4'd1) ? ST_LOCKED : ST_SYNC;
          end
        end
        ST_SYNC, ST_LOST: begin
          if (good) begin
            good_cnt_q <= gc_inc;
            if (gc_inc == LOCK_C) state_q <= ST_LOCKED;
          end else if (pair_ok) begin
            good_cnt_q <= 4'd1;
          end else begin
            good_cnt_q <= 4'd0;
            state_q    <= ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if (!good) begin
            state_q    <= ST_LOST;
            good_cnt_q <= {3'b000, pair_ok};
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    err_flag_d   = err_flag_q;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;
    // A fresh error on the clearing edge wins over the clear.
    if (lock_fail) begin
      err_flag_d  = 1'b1;
      err_count_d = clr_err ? CNT_W'(1)
                  : (err_count_q == CNT_MAX) ? CNT_MAX : err_count_q + CNT_W'(1);
    end else if (clr_err) begin
      err_flag_d  = 1'b0;
      err_count_d = '0;
    end
    if (en && state_q == ST_LOCKED && wrap) wrap_count_d = wrap_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_flag_q   <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
    end else begin
      err_flag_q   <= err_flag_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  assign state      = state_q;
  assign locked     = (state_q == ST_LOCKED);
  assign err_flag   = err_flag_q;
  assign err_count  = err_count_q;
  assign wrap_count = wrap_count_q;
  assign last_a     = last_a_q;

endmodule

// File: tb/tb_pair_seq_monitor.sv
// Scoreboard bench: a behavioural model queues expected outputs per edge, a monitor compares them.
module tb_pair_seq_monitor;

  localparam int LOCK = 4;
  localparam int S_IDLE = 0, S_SYNC = 1, S_LOCKED = 2, S_LOST = 3;

  logic       clk = 1'b0;
  logic       reset, en, clr_err;
  logic [6:0] in_a, in_b;
  logic [1:0] state;
  logic       locked, err_flag;
  logic [7:0] err_count, wrap_count;
  logic [6:0] last_a;

  always #5 clk = ~clk;

  pair_seq_monitor #(.LOCK_CNT(LOCK)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .in_a       (in_a),
    .in_b       (in_b),
    .clr_err    (clr_err),
    .state      (state),
    .locked     (locked),
    .err_flag   (err_flag),
    .err_count  (err_count),
    .wrap_count (wrap_count),
    .last_a     (last_a)
  );

  typedef struct {
    int st;
    int lk;
    int flag;
    int errc;
    int wrapc;
    int last;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  int m_state, m_gc, m_flag, m_errc, m_wrap, m_last;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_gc = 0; m_flag = 0; m_errc = 0; m_wrap = 0; m_last = 0;
  endtask

  task automatic model_step(input bit e, input int a, input int b, input bit c);
    bit pair_ok, seq_ok, err;
    pair_ok = (a % 2 == 0) && (b % 2 == 1) && (a / 2 == b / 2);
    seq_ok  = (a == (m_last + 2) % 128);
    err     = 1'b0;
    if (e) begin
      if (m_state == S_IDLE) begin
        if (pair_ok) begin
          m_gc    = 1;
          m_state = (LOCK == 1) ? S_LOCKED : S_SYNC;
        end
      end else if (m_state == S_LOCKED) begin
        if (pair_ok && seq_ok) begin
          if (m_last == 126 && a == 0) m_wrap = (m_wrap + 1) % 256;
        end else begin
          m_state = S_LOST;
          err     = 1'b1;
          m_gc    = pair_ok ? 1 : 0;
        end
      end else begin
        if (pair_ok && seq_ok) begin
          m_gc++;
          if (m_gc == LOCK) m_state = S_LOCKED;
        end else if (pair_ok) begin
          m_gc = 1;
        end else begin
          m_gc    = 0;
          m_state = S_IDLE;
        end
      end
      m_last = a;
    end
    if (err) begin
      m_flag = 1;
      m_errc = c ? 1 : ((m_errc < 255) ? m_errc + 1 : 255);
    end else if (c) begin
      m_flag = 0;
      m_errc = 0;
    end
  endtask

  function automatic exp_t snap();
    exp_t x;
    x.st = m_state; x.lk = (m_state == S_LOCKED) ? 1 : 0; x.flag = m_flag;
    x.errc = m_errc; x.wrapc = m_wrap; x.last = m_last;
    return x;
  endfunction

  task automatic step(input bit e, input int a, input int b, input bit c);
    en = e; in_a = 7'(a); in_b = 7'(b); clr_err = c;
    @(posedge clk);
    model_step(e, a, b, c);
    sb_q.push_back(snap());
    #1;
  endtask

  task automatic good_step();
    int a;
    a = (m_last + 2) % 128;
    step(1'b1, a, a + 1, 1'b0);
  endtask

  task automatic bad_step(input bit c);
    int a;
    a = (m_last + 2) % 128;
    step(1'b1, a, a, c);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      check("sb_state",      int'(state),      x.st);
      check("sb_locked",     int'(locked),     x.lk);
      check("sb_err_flag",   int'(err_flag),   x.flag);
      check("sb_err_count",  int'(err_count),  x.errc);
      check("sb_wrap_count", int'(wrap_count), x.wrapc);
      check("sb_last_a",     int'(last_a),     x.last);
    end
  end

  initial begin
    reset = 1'b0; en = 1'b0; clr_err = 1'b0; in_a = '0; in_b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    settle();
    check("rst_state", int'(state), S_IDLE);
    check("rst_locked", int'(locked), 0);
    check("rst_err_count", int'(err_count), 0);
    check("rst_wrap_count", int'(wrap_count), 0);

    // Lock-in
    step(1'b1, 0, 1, 1'b0);
    settle();
    check("lockin_sync", int'(state), S_SYNC);
    step(1'b1, 2, 3, 1'b0);
    step(1'b1, 4, 5, 1'b0);
    step(1'b1, 6, 7, 1'b0);
    settle();
    check("lockin_locked", int'(locked), 1);
    check("lockin_err_count", int'(err_count), 0);

    // Wrap through 126 -> 0, then one full lap
    for (int i = 0; i < 200 && m_last != 126; i++) good_step();
    good_step();
    settle();
    check("wrap1_count", int'(wrap_count), 1);
    check("wrap1_locked", int'(locked), 1);
    repeat (64) good_step();
    settle();
    check("wrap2_count", int'(wrap_count), 2);

    // Error and relock
    repeat (4) good_step();
    step(1'b1, 10, 13, 1'b0);
    settle();
    check("err_state", int'(state), S_LOST);
    check("err_flag", int'(err_flag), 1);
    check("err_count", int'(err_count), 1);
    check("err_locked", int'(locked), 0);
    step(1'b1, 12, 13, 1'b0);
    step(1'b1, 14, 15, 1'b0);
    step(1'b1, 16, 17, 1'b0);
    step(1'b1, 18, 19, 1'b0);
    settle();
    check("relock_locked", int'(locked), 1);
    check("relock_err_count", int'(err_count), 1);

    // Hold with en low
    repeat (5) step(1'b0, $urandom_range(0, 127), $urandom_range(0, 127), 1'b0);
    settle();
    check("hold_last_a", int'(last_a), 18);
    check("hold_locked", int'(locked), 1);
    good_step();
    settle();
    check("resume_locked", int'(locked), 1);
    check("resume_err_count", int'(err_count), 1);

    // Randomised mix of good, broken, skipped and idle samples
    for (int i = 0; i < 400; i++) begin
      int r, a;
      r = $urandom_range(0, 9);
      if (r <= 5) good_step();
      else if (r == 6) step(1'b1, $urandom_range(0, 63) * 2, $urandom_range(0, 127), 1'b0);
      else if (r == 7) begin
        a = (m_last + 4) % 128;
        step(1'b1, a, a + 1, 1'b0);
      end else if (r == 8) step(1'b0, $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 1));
      else begin
        a = (m_last + 2) % 128;
        step(1'b1, a, a + 1, 1'b1);
      end
    end

    // Saturation
    for (int i = 0; i < 20 && m_state != S_LOCKED; i++) good_step();
    repeat (256) begin
      bad_step(1'b0);
      repeat (LOCK) good_step();
    end
    settle();
    check("sat_err_count", int'(err_count), 255);
    check("sat_locked", int'(locked), 1);

    bad_step(1'b1);
    settle();
    check("clr_vs_err_count", int'(err_count), 1);
    check("clr_vs_err_flag", int'(err_flag), 1);
    step(1'b0, 0, 0, 1'b1);
    settle();
    check("clr_count", int'(err_count), 0);
    check("clr_flag", int'(err_flag), 0);

    // Async reset while locked with three wraps
    reset = 1'b0;
    #1 reset = 1'b1;
    model_reset();
    for (int i = 0; i < 1000 && m_wrap < 3; i++) good_step();
    good_step();
    settle();
    check("pre_rst_locked", int'(locked), 1);
    check("pre_rst_wrap", int'(wrap_count), 3);
    reset = 1'b0;
    #1;
    check("arst_state", int'(state), S_IDLE);
    check("arst_locked", int'(locked), 0);
    check("arst_err_flag", int'(err_flag), 0);
    check("arst_err_count", int'(err_count), 0);
    check("arst_wrap_count", int'(wrap_count), 0);
    check("arst_last_a", int'(last_a), 0);
    model_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    step(1'b1, 40, 41, 1'b0);
    settle();
    check("post_rst_sync", int'(state), S_SYNC);

    repeat (2) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
